// File: rtl/xbar_pkg.sv
// xbar_pkg: shared AXI widths, AW channel types and mux FSM states for the crossbar.
//   aw_chan_t     : upstream AW beat {id,addr,len,size,burst,user}
//   aw_mux_chan_t : downstream AW beat, ID widened by AXI_IDX_WIDTH (master index in the MSBs)
package xbar_pkg;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 64;
  localparam int AXI_ID_WIDTH   = 6;
  localparam int AXI_USER_WIDTH = 8;
  localparam int AXI_NUM_MST    = 4;
  localparam int AXI_IDX_WIDTH  = $clog2(AXI_NUM_MST);
  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;
  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } mux_state_e;
  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [7:0]                len;
    logic [2:0]                size;
    burst_t                    burst;
    logic [AXI_USER_WIDTH-1:0] user;
  } aw_chan_t;
  typedef struct packed {
    logic [AXI_IDX_WIDTH+AXI_ID_WIDTH-1:0] id;
    logic [AXI_ADDR_WIDTH-1:0]             addr;
    logic [7:0]                            len;
    logic [2:0]                            size;
    burst_t                                burst;
    logic [AXI_USER_WIDTH-1:0]             user;
  } aw_mux_chan_t;
  function automatic aw_mux_chan_t widen_id(input logic [AXI_IDX_WIDTH-1:0] idx, input aw_chan_t c);
    return '{id: {idx, c.id}, addr: c.addr, len: c.len, size: c.size, burst: c.burst, user: c.user};
  endfunction
endpackage

// File: rtl/xbar_spill_reg.sv
// xbar_spill_reg: generic 2-entry valid/ready register; ready_o depends only on occupancy.
//   clk_i, rst_i (async, active-high) ; valid_i/ready_o/data_i upstream ; valid_o/ready_i/data_o downstream
module xbar_spill_reg #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);
  T           mem_q [2];
  logic       wr_q, rd_q;
  logic [1:0] cnt_q;
  logic       push, pop;
  assign ready_o = cnt_q != 2'd2;
  assign valid_o = cnt_q != 2'd0;
  assign data_o  = mem_q[rd_q];
  assign push    = valid_i && ready_o;
  assign pop     = valid_o && ready_i;
  always_ff @(posedge clk_i)
    if (push) mem_q[wr_q] <= data_i;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) wr_q <= ~wr_q;
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
endmodule

// File: rtl/xbar_aw_rr_mux.sv
// xbar_aw_rr_mux: round-robin N-to-1 AW mux with grant lock until handshake and master-index ID prefix.
//   clk_i, rst_i (async, active-high)
//   slv_aw_valid_i/slv_aw_ready_o/slv_aw_chan_i : per-master AW inputs
//   mst_aw_valid_o/mst_aw_ready_i/mst_aw_chan_o : AW towards slave, ID = {idx,id}
//   grant_idx_o : index of the master currently presented
//   Macro XBAR_AW_MUX_SPILL_EN : insert a 2-entry spill register on the master side.
module xbar_aw_rr_mux import xbar_pkg::*; #(
  parameter  int NUM_MST = 4,
  parameter  int ADDR_W  = AXI_ADDR_WIDTH,
  parameter  int ID_W    = AXI_ID_WIDTH,
  parameter  int USER_W  = AXI_USER_WIDTH,
  localparam int IDX_W   = $clog2(NUM_MST)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_MST-1:0]       slv_aw_valid_i,
  output logic [NUM_MST-1:0]       slv_aw_ready_o,
  input  aw_chan_t [NUM_MST-1:0]   slv_aw_chan_i,
  output logic                     mst_aw_valid_o,
  input  logic                     mst_aw_ready_i,
  output aw_mux_chan_t             mst_aw_chan_o,
  output logic [IDX_W-1:0]         grant_idx_o
);
  if (ADDR_W != AXI_ADDR_WIDTH || ID_W != AXI_ID_WIDTH || USER_W != AXI_USER_WIDTH || IDX_W != AXI_IDX_WIDTH) begin : g_bad_cfg
    $error("xbar_aw_rr_mux: parameters must match the xbar_pkg channel widths");
  end
  mux_state_e       state_q;
  logic [IDX_W-1:0] rr_q, rr_d, lock_idx_q, win, cand, grant;
  logic             found, arb_valid, arb_ready;
  aw_mux_chan_t     arb_chan;
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_MST; k++) begin
      cand = IDX_W'((int'(rr_q) + k) % NUM_MST);
      if (!found && slv_aw_valid_i[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end
  // A locked grant keeps valid high even if its master misbehaves and drops valid.
  assign grant          = (state_q == ST_LOCKED) ? lock_idx_q : win;
  assign arb_valid      = !rst_i && (state_q == ST_LOCKED || |slv_aw_valid_i);
  assign arb_chan       = widen_id(grant, slv_aw_chan_i[grant]);
  assign rr_d           = (int'(grant) == NUM_MST - 1) ? '0 : grant + 1'b1;
  assign slv_aw_ready_o = (arb_valid && arb_ready) ? NUM_MST'(1) << grant : '0;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q    <= ST_IDLE;
      rr_q       <= '0;
      lock_idx_q <= '0;
    end else if (arb_valid && arb_ready) begin
      state_q <= ST_IDLE;
      rr_q    <= rr_d;
    end else if (arb_valid) begin
      state_q    <= ST_LOCKED;
      lock_idx_q <= grant;
    end
`ifdef XBAR_AW_MUX_SPILL_EN
  aw_mux_chan_t sp_chan;
  xbar_spill_reg #(.T(aw_mux_chan_t)) u_spill (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (arb_valid),
    .ready_o (arb_ready),
    .data_i  (arb_chan),
    .valid_o (mst_aw_valid_o),
    .ready_i (mst_aw_ready_i),
    .data_o  (sp_chan)
  );
  assign mst_aw_chan_o = sp_chan;
  assign grant_idx_o   = mst_aw_valid_o ? sp_chan.id[AXI_ID_WIDTH +: IDX_W] : '0;
`else
  assign arb_ready      = mst_aw_ready_i;
  assign mst_aw_valid_o = arb_valid;
  assign mst_aw_chan_o  = arb_chan;
  assign grant_idx_o    = rst_i ? '0 : grant;
`endif
  a_locked_valid_held: assert property (@(posedge clk_i) disable iff (rst_i)
    state_q == ST_LOCKED |-> slv_aw_valid_i[lock_idx_q]);
endmodule
